// File: rtl/xm23_alu_if.sv
// Operand, control and result bundle between the XM23 control/datapath and its ALU.
interface xm23_alu_if;
    logic [15:0] s_bus;
    logic [15:0] d_bus;
    logic [5:0]  alu_op;
    logic [15:0] psw_in;
    logic        alu_E;
    logic        psw_update;
    logic [15:0] alu_out;
    logic [15:0] alu_psw_out;

    modport master (
        output s_bus, d_bus, alu_op, psw_in, alu_E, psw_update,
        input  alu_out, alu_psw_out
    );

    modport slave (
        input  s_bus, d_bus, alu_op, psw_in, alu_E, psw_update,
        output alu_out, alu_psw_out
    );
endinterface

// File: rtl/xm23_alu.sv
// XM23 registered ALU: one-cycle result and PSW (C/Z/N/V) update, word or byte mode.
module xm23_alu (
    input  logic        Clock,
    input  logic        Reset_n,
    xm23_alu_if.slave   bus
);

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_ADDC = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_SUBC = 5'd3;
    localparam logic [4:0] OP_DADD = 5'd4;
    localparam logic [4:0] OP_CMP  = 5'd5;
    localparam logic [4:0] OP_XOR  = 5'd6;
    localparam logic [4:0] OP_AND  = 5'd7;
    localparam logic [4:0] OP_OR   = 5'd8;
    localparam logic [4:0] OP_BIT  = 5'd9;
    localparam logic [4:0] OP_BIC  = 5'd10;
    localparam logic [4:0] OP_BIS  = 5'd11;
    localparam logic [4:0] OP_MOV  = 5'd12;
    localparam logic [4:0] OP_SRA  = 5'd13;
    localparam logic [4:0] OP_RRC  = 5'd14;
    localparam logic [4:0] OP_SWPB = 5'd15;
    localparam logic [4:0] OP_SXT  = 5'd16;

    function automatic logic msb_of(input logic [15:0] x, input logic byte_m);
        return byte_m ? x[7] : x[15];
    endfunction

    function automatic logic zero_of(input logic [15:0] x, input logic byte_m);
        return byte_m ? (x[7:0] == 8'h00) : (x == 16'h0000);
    endfunction

    logic [4:0]  opc;
    logic        byte_m;
    logic        c_in;
    logic        sub_op;
    logic [15:0] d;
    logic [15:0] s;
    logic [15:0] b_op;
    logic        add_cin;
    logic [16:0] sum_w;
    logic [8:0]  sum_b;
    logic [15:0] add_res;
    logic        add_c;
    logic [15:0] dadd_res;
    logic        dadd_c;
    logic [4:0]  nib;
    logic [4:0]  nib_adj;
    logic [15:0] logic_src;
    logic [15:0] res;
    logic [15:0] flag_src;
    logic        upd_c;
    logic        upd_zn;
    logic        upd_v;
    logic        new_c;
    logic        new_v;
    logic        flag_byte;
    logic [15:0] psw_new;
    logic [15:0] alu_out_d;
    logic [15:0] alu_out_q;
    logic [15:0] alu_psw_out_d;
    logic [15:0] alu_psw_out_q;

    assign opc    = bus.alu_op[4:0];
    assign byte_m = bus.alu_op[5] && (opc <= OP_RRC);
    assign d      = bus.d_bus;
    assign s      = bus.s_bus;
    assign c_in   = bus.psw_in[0];

    // Shared adder for ADD/ADDC/SUB/SUBC/CMP, both widths computed and selected
    always_comb begin
        sub_op = (opc == OP_SUB) || (opc == OP_SUBC) || (opc == OP_CMP);
        if (sub_op) begin
            b_op = ~s;
        end else begin
            b_op = s;
        end
        case (opc)
            OP_ADD:  add_cin = 1'b0;
            OP_ADDC: add_cin = c_in;
            OP_SUB:  add_cin = 1'b1;
            OP_SUBC: add_cin = c_in;
            OP_CMP:  add_cin = 1'b1;
            default: add_cin = 1'b0;
        endcase
        sum_w = {1'b0, d} + {1'b0, b_op} + {16'd0, add_cin};
        sum_b = {1'b0, d[7:0]} + {1'b0, b_op[7:0]} + {8'd0, add_cin};
        if (byte_m) begin
            add_res = {d[15:8], sum_b[7:0]};
            add_c   = sum_b[8];
        end else begin
            add_res = sum_w[15:0];
            add_c   = sum_w[16];
        end
    end

    // BCD add, nibble by nibble; byte mode stops after two nibbles and keeps D[15:8]
    always_comb begin
        dadd_res = d;
        dadd_c   = c_in;
        nib      = 5'd0;
        nib_adj  = 5'd0;
        for (int i = 0; i < 4; i++) begin
            if ((i < 2) || !byte_m) begin
                nib     = {1'b0, d[4*i +: 4]} + {1'b0, s[4*i +: 4]} + {4'd0, dadd_c};
                nib_adj = nib - 5'd10;
                if (nib > 5'd9) begin
                    dadd_res[4*i +: 4] = nib_adj[3:0];
                    dadd_c             = 1'b1;
                end else begin
                    dadd_res[4*i +: 4] = nib[3:0];
                    dadd_c             = 1'b0;
                end
            end else begin
                dadd_res[4*i +: 4] = d[4*i +: 4];
            end
        end
    end

    // Result select and per-opcode flag-update masks
    always_comb begin
        res       = d;
        flag_src  = d;
        logic_src = d;
        upd_c     = 1'b0;
        upd_zn    = 1'b0;
        upd_v     = 1'b0;
        new_c     = c_in;
        new_v     = bus.psw_in[4];
        flag_byte = byte_m;
        case (opc)
            OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP: begin
                res      = (opc == OP_CMP) ? d : add_res;
                flag_src = add_res;
                upd_c    = 1'b1;
                upd_zn   = 1'b1;
                upd_v    = 1'b1;
                new_c    = add_c;
                new_v    = (msb_of(d, byte_m) == msb_of(b_op, byte_m)) &&
                           (msb_of(add_res, byte_m) != msb_of(d, byte_m));
            end
            OP_DADD: begin
                res      = dadd_res;
                flag_src = dadd_res;
                upd_c    = 1'b1;
                upd_zn   = 1'b1;
                new_c    = dadd_c;
            end
            OP_XOR, OP_AND, OP_OR, OP_BIT, OP_BIC, OP_BIS: begin
                case (opc)
                    OP_XOR:  logic_src = d ^ s;
                    OP_AND:  logic_src = d & s;
                    OP_OR:   logic_src = d | s;
                    OP_BIT:  logic_src = d & s;
                    OP_BIC:  logic_src = d & ~s;
                    OP_BIS:  logic_src = d | s;
                    default: logic_src = d;
                endcase
                if (byte_m) begin
                    logic_src = {d[15:8], logic_src[7:0]};
                end else begin
                    logic_src = logic_src;
                end
                res      = (opc == OP_BIT) ? d : logic_src;
                flag_src = logic_src;
                upd_zn   = 1'b1;
            end
            OP_MOV: begin
                res = byte_m ? {d[15:8], s[7:0]} : s;
            end
            OP_SRA, OP_RRC: begin
                if (byte_m) begin
                    res = {d[15:8], (opc == OP_SRA) ? d[7] : c_in, d[7:1]};
                end else begin
                    res = {(opc == OP_SRA) ? d[15] : c_in, d[15:1]};
                end
                flag_src = res;
                upd_c    = 1'b1;
                upd_zn   = 1'b1;
                new_c    = d[0];
            end
            OP_SWPB, OP_SXT: begin
                res       = (opc == OP_SWPB) ? {d[7:0], d[15:8]} : {{8{d[7]}}, d[7:0]};
                flag_src  = res;
                upd_zn    = 1'b1;
                flag_byte = 1'b0;
            end
            default: begin
                res = d;
            end
        endcase
    end

    // Merge flags into psw_in and compute the next register values
    always_comb begin
        psw_new = bus.psw_in;
        if (bus.psw_update) begin
            if (upd_c) begin
                psw_new[0] = new_c;
            end else begin
                psw_new[0] = bus.psw_in[0];
            end
            if (upd_zn) begin
                psw_new[1] = zero_of(flag_src, flag_byte);
                psw_new[2] = msb_of(flag_src, flag_byte);
            end else begin
                psw_new[2:1] = bus.psw_in[2:1];
            end
            if (upd_v) begin
                psw_new[4] = new_v;
            end else begin
                psw_new[4] = bus.psw_in[4];
            end
        end else begin
            psw_new = bus.psw_in;
        end
        if (bus.alu_E) begin
            alu_out_d     = res;
            alu_psw_out_d = psw_new;
        end else begin
            alu_out_d     = alu_out_q;
            alu_psw_out_d = alu_psw_out_q;
        end
    end

    // Output registers, cleared asynchronously
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            alu_out_q     <= 16'h0000;
            alu_psw_out_q <= 16'h0000;
        end else begin
            alu_out_q     <= alu_out_d;
            alu_psw_out_q <= alu_psw_out_d;
        end
    end

    assign bus.alu_out     = alu_out_q;
    assign bus.alu_psw_out = alu_psw_out_q;

endmodule

// File: tb/tb_xm23_alu.sv
// Directed-vector bench for xm23_alu with hand-computed results and PSW values.
module tb_xm23_alu;

    logic Clock;
    logic Reset_n;
    int   n_checks;
    int   n_errors;

    xm23_alu_if bus ();

    xm23_alu dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .bus     (bus.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %04h expected %04h", tag, act, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic bm, input logic [4:0] op,
                          input logic [15:0] dv, input logic [15:0] sv,
                          input logic [15:0] psw, input logic upd,
                          input logic [15:0] exp_out, input logic [15:0] exp_psw);
        bus.alu_E      = 1'b1;
        bus.alu_op     = {bm, op};
        bus.d_bus      = dv;
        bus.s_bus      = sv;
        bus.psw_in     = psw;
        bus.psw_update = upd;
        @(posedge Clock);
        #1;
        check_val({tag, "_out"}, bus.alu_out, exp_out);
        check_val({tag, "_psw"}, bus.alu_psw_out, exp_psw);
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        Reset_n        = 1'b0;
        bus.alu_E      = 1'b0;
        bus.alu_op     = 6'd0;
        bus.d_bus      = 16'h0000;
        bus.s_bus      = 16'h0000;
        bus.psw_in     = 16'h0000;
        bus.psw_update = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        check_val("reset_out", bus.alu_out, 16'h0000);
        check_val("reset_psw", bus.alu_psw_out, 16'h0000);
        @(negedge Clock);
        Reset_n = 1'b1;

        //      tag        byte op     D         S         psw_in    upd   out       psw
        run_op("add_w",    1'b0, 5'd0,  16'h7FFF, 16'h0001, 16'h0000, 1'b1, 16'h8000, 16'h0014);
        run_op("sub_b",    1'b1, 5'd2,  16'hAB05, 16'h0005, 16'h0000, 1'b1, 16'hAB00, 16'h0003);
        run_op("dadd_w1",  1'b0, 5'd4,  16'h0019, 16'h0001, 16'h0000, 1'b1, 16'h0020, 16'h0000);
        run_op("dadd_w2",  1'b0, 5'd4,  16'h9999, 16'h0001, 16'h0000, 1'b1, 16'h0000, 16'h0003);
        run_op("dadd_b",   1'b1, 5'd4,  16'h1299, 16'h0001, 16'h0000, 1'b1, 16'h1200, 16'h0003);
        run_op("rrc_w",    1'b0, 5'd14, 16'h0001, 16'h0000, 16'h0001, 1'b1, 16'h8000, 16'h0005);
        run_op("cmp_w",    1'b0, 5'd5,  16'h1234, 16'h1234, 16'h0000, 1'b1, 16'h1234, 16'h0003);
        run_op("cmp_noupd",1'b0, 5'd5,  16'h1234, 16'h1234, 16'h0108, 1'b0, 16'h1234, 16'h0108);
        run_op("addc_b",   1'b1, 5'd1,  16'h12FF, 16'h0000, 16'h0009, 1'b1, 16'h1200, 16'h000B);
        run_op("swpb",     1'b1, 5'd15, 16'h12AB, 16'h0000, 16'h0011, 1'b1, 16'hAB12, 16'h0015);
        run_op("sxt",      1'b0, 5'd16, 16'h3480, 16'h0000, 16'h0000, 1'b1, 16'hFF80, 16'h0004);
        run_op("sra_b",    1'b1, 5'd13, 16'h5681, 16'h0000, 16'h0000, 1'b1, 16'h56C0, 16'h0005);
        run_op("mov",      1'b0, 5'd12, 16'h1111, 16'hBEEF, 16'h0017, 1'b1, 16'hBEEF, 16'h0017);
        run_op("undef",    1'b0, 5'd20, 16'h4321, 16'h0000, 16'h0002, 1'b1, 16'h4321, 16'h0002);
        run_op("bic_w",    1'b0, 5'd10, 16'hFF0F, 16'h000F, 16'h0011, 1'b1, 16'hFF00, 16'h0015);
        run_op("bit_w",    1'b0, 5'd9,  16'h00F0, 16'h0F00, 16'h0000, 1'b1, 16'h00F0, 16'h0002);
        run_op("subc_w",   1'b0, 5'd3,  16'h8000, 16'h0001, 16'h0000, 1'b1, 16'h7FFE, 16'h0011);

        // Disabled edges must hold the previous result whatever the inputs do
        bus.alu_E  = 1'b0;
        bus.alu_op = 6'd0;
        bus.d_bus  = 16'h5555;
        bus.s_bus  = 16'h1111;
        bus.psw_in = 16'hFFFF;
        repeat (2) @(posedge Clock);
        #1;
        check_val("hold_out", bus.alu_out, 16'h7FFE);
        check_val("hold_psw", bus.alu_psw_out, 16'h0011);

        // Asynchronous reset mid-stream, then disabled edges after release
        run_op("pre_rst",  1'b0, 5'd6,  16'hF0F0, 16'h0FF0, 16'h0000, 1'b1, 16'hFF00, 16'h0004);
        #2;
        Reset_n = 1'b0;
        #1;
        check_val("async_rst_out", bus.alu_out, 16'h0000);
        check_val("async_rst_psw", bus.alu_psw_out, 16'h0000);
        bus.alu_E = 1'b0;
        @(negedge Clock);
        Reset_n = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        check_val("post_rst_out", bus.alu_out, 16'h0000);
        check_val("post_rst_psw", bus.alu_psw_out, 16'h0000);
        run_op("or_b",     1'b1, 5'd8,  16'hAA00, 16'h0081, 16'h0000, 1'b1, 16'hAA81, 16'h0004);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
